// File: rtl/ofs_plat_ccip_c1_burst_arbiter_if.sv
// CCI-P c1 burst arbiter bus: per-source write beats in, one registered
// beat stream out to the sink, plus sink almost-full and burst error flag.
interface ofs_plat_ccip_c1_burst_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH  = 80
);
  localparam int SW = $clog2(N_SRC);

  logic [N_SRC-1:0]            src_valid;
  logic [N_SRC-1:0]            src_sop;
  logic [N_SRC-1:0]            src_eop;
  logic [N_SRC*HDR_WIDTH-1:0]  src_hdr;
  logic [N_SRC*DATA_WIDTH-1:0] src_data;
  logic [N_SRC-1:0]            src_ready;
  logic                        c1TxAlmFull;
  logic                        tx_valid;
  logic                        tx_sop;
  logic [HDR_WIDTH-1:0]        tx_hdr;
  logic [DATA_WIDTH-1:0]       tx_data;
  logic [SW-1:0]               tx_src;
  logic                        err_burst_len;

  modport master (
    output src_valid, src_sop, src_eop,
    output src_hdr, src_data, c1TxAlmFull,
    input  src_ready, tx_valid, tx_sop,
    input  tx_hdr, tx_data, tx_src,
    input  err_burst_len
  );

  modport slave (
    input  src_valid, src_sop, src_eop,
    input  src_hdr, src_data, c1TxAlmFull,
    output src_ready, tx_valid, tx_sop,
    output tx_hdr, tx_data, tx_src,
    output err_burst_len
  );
endinterface

// File: rtl/ofs_plat_ccip_c1_burst_arbiter.sv
// Round-robin c1 write arbiter: locks onto one source for a whole burst
// (max 4 beats), registers each accepted beat toward the sink.
module ofs_plat_ccip_c1_burst_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH  = 80
) (
  input logic clk,
  input logic reset,
  ofs_plat_ccip_c1_burst_arbiter_if.slave bus
);
  localparam int SW = $clog2(N_SRC);
  localparam logic [SW-1:0] LAST = SW'(N_SRC - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         owner_q, owner_d;
  logic [SW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  alm_full_q, alm_full_d;
  logic                  err_q, err_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sop_q, tx_sop_d;
  logic [HDR_WIDTH-1:0]  tx_hdr_q, tx_hdr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [SW-1:0]         tx_src_q, tx_src_d;

  logic                  grant_vld;
  logic [SW-1:0]         grant_idx;
  logic [SW-1:0]         cand;
  logic                  accept;
  logic [N_SRC-1:0]      ready;

  function automatic logic [SW-1:0] wrap_inc(
    input logic [SW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Idle search starts at rr_ptr; only SOP beats may open a burst
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = rr_ptr_q;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = owner_q;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!grant_vld && bus.src_valid[cand]
            && bus.src_sop[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
        cand = wrap_inc(cand);
      end
    end
  end

  assign accept = grant_vld && !alm_full_q
                  && bus.src_valid[grant_idx];

  always_comb begin
    ready = '0;
    if (accept) ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    alm_full_d = bus.c1TxAlmFull;
    tx_valid_d = 1'b0;
    tx_sop_d   = tx_sop_q;
    tx_hdr_d   = tx_hdr_q;
    tx_data_d  = tx_data_q;
    tx_src_d   = tx_src_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_sop_d   = bus.src_sop[grant_idx];
      tx_hdr_d   = bus.src_hdr[grant_idx*HDR_WIDTH +: HDR_WIDTH];
      tx_data_d  = bus.src_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      tx_src_d   = grant_idx;
      if (bus.src_eop[grant_idx]) begin
        state_d  = IDLE;
        cnt_d    = 3'd0;
        rr_ptr_d = wrap_inc(grant_idx);
      end else if (state_q == LOCKED && cnt_q == 3'd4) begin
        // Fifth beat with no EOP: flag it and drop the lock
        err_d    = 1'b1;
        state_d  = IDLE;
        cnt_d    = 3'd0;
        rr_ptr_d = wrap_inc(grant_idx);
      end else begin
        state_d  = LOCKED;
        owner_d  = grant_idx;
        cnt_d    = (state_q == IDLE) ? 3'd1 : cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= 3'd0;
      alm_full_q <= 1'b1;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_hdr_q   <= '0;
      tx_data_q  <= '0;
      tx_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      alm_full_q <= alm_full_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_hdr_q   <= tx_hdr_d;
      tx_data_q  <= tx_data_d;
      tx_src_q   <= tx_src_d;
    end
  end

  assign bus.src_ready     = ready;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_sop        = tx_sop_q;
  assign bus.tx_hdr        = tx_hdr_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_src        = tx_src_q;
  assign bus.err_burst_len = err_q;

endmodule

// File: tb/tb_ofs_plat_ccip_c1_burst_arbiter.sv
// Bench for the c1 burst arbiter: per-source burst queues feed the DUT,
// a burst-level arbitration model predicts ready and the tx stream.
module tb_ofs_plat_ccip_c1_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int HW = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ofs_plat_ccip_c1_burst_arbiter_if #(
    .N_SRC(N), .DATA_WIDTH(DW), .HDR_WIDTH(HW)
  ) bus ();

  ofs_plat_ccip_c1_burst_arbiter #(
    .N_SRC(N), .DATA_WIDTH(DW), .HDR_WIDTH(HW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic          sop;
    logic          eop;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t srcq[N][$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: burst ownership, rotation pointer, beats in burst
  bit            m_af, m_locked, m_err;
  int            m_owner, m_ptr, m_beats;
  bit            m_txv, m_sop;
  logic [HW-1:0] m_hdr;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_src;
  int            acc;

  int obs_code, obs_n, obs_first, obs_last, stepno;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += srcq[i].size();
    return s;
  endfunction

  task automatic push_burst(input int src, input int len, input bit last_eop);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.sop  = (k == 0);
      b.eop  = last_eop && (k == len - 1);
      b.hdr  = HW'($urandom);
      b.data = {$urandom(), $urandom()};
      srcq[src].push_back(b);
    end
  endtask

  task automatic step(input bit af, input int thr);
    logic [N-1:0]    v, s, e, exp_rdy;
    logic [N*HW-1:0] hv;
    logic [N*DW-1:0] dv;
    beat_t           b;
    int              g, idx;
    @(negedge clk);
    stepno++;
    n_cmp++;
    if (bus.tx_valid !== m_txv) begin
      n_bad++;
      $display("FAIL tx_valid step %0d: got %b want %b", stepno, bus.tx_valid, m_txv);
    end
    n_cmp++;
    if ({bus.tx_sop, bus.tx_hdr, bus.tx_data, bus.tx_src}
        !== {m_sop, m_hdr, m_data, m_src}) begin
      n_bad++;
      $display("FAIL tx_beat step %0d: got %h want %h", stepno,
               {bus.tx_sop, bus.tx_hdr, bus.tx_data, bus.tx_src},
               {m_sop, m_hdr, m_data, m_src});
    end
    n_cmp++;
    if (bus.err_burst_len !== m_err) begin
      n_bad++;
      $display("FAIL err_burst_len step %0d: got %b want %b", stepno, bus.err_burst_len, m_err);
    end
    if (bus.tx_valid === 1'b1) begin
      obs_code = obs_code * 10 + int'(bus.tx_src) + 1;
      if (obs_n == 0) obs_first = stepno;
      obs_last = stepno;
      obs_n++;
    end
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && $urandom_range(99) >= thr) begin
        v[i] = 1'b1;
        s[i] = srcq[i][0].sop;
        e[i] = srcq[i][0].eop;
        hv[i*HW +: HW] = srcq[i][0].hdr;
        dv[i*DW +: DW] = srcq[i][0].data;
      end else begin
        v[i] = 1'b0;
        s[i] = 1'($urandom_range(1));
        e[i] = 1'($urandom_range(1));
        hv[i*HW +: HW] = HW'($urandom);
        dv[i*DW +: DW] = {$urandom(), $urandom()};
      end
    end
    bus.src_valid   = v;
    bus.src_sop     = s;
    bus.src_eop     = e;
    bus.src_hdr     = hv;
    bus.src_data    = dv;
    bus.c1TxAlmFull = af;
    #1;
    g = -1;
    if (!m_af) begin
      if (m_locked) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && v[idx] && s[idx]) g = idx;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    n_cmp++;
    if (bus.src_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL src_ready step %0d: got %b want %b", stepno, bus.src_ready, exp_rdy);
    end
    m_txv = 1'b0;
    if (g >= 0) begin
      b = srcq[g].pop_front();
      m_txv  = 1'b1;
      m_sop  = b.sop;
      m_hdr  = b.hdr;
      m_data = b.data;
      m_src  = SW'(g);
      m_beats = (m_locked ? m_beats : 0) + 1;
      acc++;
      if (b.eop || m_beats == 5) begin
        if (!b.eop) m_err = 1'b1;
        m_locked = 1'b0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end
    m_af = af;
  endtask

  task automatic do_reset(input bit clr);
    @(negedge clk);
    reset = 1'b1;
    bus.src_valid   = '1;
    bus.src_sop     = '1;
    bus.src_eop     = '1;
    bus.src_hdr     = '1;
    bus.src_data    = '1;
    bus.c1TxAlmFull = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid);
    end
    n_cmp++;
    if ({bus.tx_sop, bus.tx_hdr, bus.tx_data, bus.tx_src} !== '0) begin
      n_bad++;
      $display("FAIL rst_tx_fields: got %h want 0",
               {bus.tx_sop, bus.tx_hdr, bus.tx_data, bus.tx_src});
    end
    n_cmp++;
    if (bus.err_burst_len !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_err: got %b want 0", bus.err_burst_len);
    end
    n_cmp++;
    if (bus.src_ready !== '0) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0", bus.src_ready);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.src_ready !== '0) begin
      n_bad++;
      $display("FAIL post_rst_ready: got %b want 0", bus.src_ready);
    end
    bus.src_valid = '0;
    m_af = 1'b0;
    m_locked = 1'b0;
    m_err = 1'b0;
    m_owner = 0;
    m_ptr = 0;
    m_beats = 0;
    m_txv = 1'b0;
    m_sop = 1'b0;
    m_hdr = '0;
    m_data = '0;
    m_src = '0;
    acc = 0;
    obs_code = 0;
    obs_n = 0;
    if (clr) for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic run(input int thr, input int afp, input int keep, input int max);
    int n = 0;
    while (pending() > keep && n < max) begin
      step($urandom_range(99) < afp, thr);
      n++;
    end
    if (pending() > keep) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending want %0d", pending(), keep);
    end
    step(1'b0, 0);
    step(1'b0, 0);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
  endtask

  task automatic test_single_lines();
    do_reset(1'b1);
    for (int i = 0; i < N; i++) push_burst(i, 1, 1'b1);
    run(0, 0, 0, 50);
    n_cmp++;
    if (obs_code !== 1234) begin
      n_bad++;
      $display("FAIL single_order: got %0d want 1234", obs_code);
    end
    n_cmp++;
    if (obs_last - obs_first !== 3) begin
      n_bad++;
      $display("FAIL single_b2b: got span %0d want 3", obs_last - obs_first);
    end
  endtask

  task automatic test_lock();
    do_reset(1'b1);
    push_burst(1, 4, 1'b1);
    push_burst(2, 1, 1'b1);
    run(0, 0, 0, 50);
    n_cmp++;
    if (obs_code !== 22223) begin
      n_bad++;
      $display("FAIL lock_order: got %0d want 22223", obs_code);
    end
  endtask

  task automatic test_alm_full();
    do_reset(1'b1);
    push_burst(0, 3, 1'b1);
    for (int k = 0; k < 12; k++) step(k >= 1 && k <= 5, 0);
    n_cmp++;
    if (obs_code !== 111) begin
      n_bad++;
      $display("FAIL almfull_beats: got %0d want 111", obs_code);
    end
    n_cmp++;
    if (obs_last - obs_first !== 7) begin
      n_bad++;
      $display("FAIL almfull_stall: got span %0d want 7", obs_last - obs_first);
    end
  endtask

  task automatic test_burst_len();
    do_reset(1'b1);
    push_burst(0, 5, 1'b0);
    push_burst(1, 1, 1'b1);
    run(0, 0, 0, 50);
    n_cmp++;
    if (obs_code !== 111112) begin
      n_bad++;
      $display("FAIL burstlen_order: got %0d want 111112", obs_code);
    end
    n_cmp++;
    if (bus.err_burst_len !== 1'b1) begin
      n_bad++;
      $display("FAIL burstlen_err: got %b want 1", bus.err_burst_len);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset(1'b1);
    push_burst(0, 4, 1'b1);
    while (acc < 2 && n < 20) begin
      step(1'b0, 0);
      n++;
    end
    do_reset(1'b0);
    push_burst(3, 1, 1'b1);
    run(0, 0, 2, 50);
    n_cmp++;
    if (obs_code !== 4) begin
      n_bad++;
      $display("FAIL rstmid_order: got %0d want 4", obs_code);
    end
    n_cmp++;
    if (srcq[0].size() !== 2) begin
      n_bad++;
      $display("FAIL rstmid_remainder: got %0d left want 2", srcq[0].size());
    end
  endtask

  task automatic test_no_sop();
    beat_t b;
    do_reset(1'b1);
    b.sop = 1'b0;
    b.eop = 1'b0;
    b.hdr = HW'($urandom);
    b.data = {$urandom(), $urandom()};
    srcq[2].push_back(b);
    push_burst(1, 1, 1'b1);
    run(0, 0, 1, 50);
    for (int k = 0; k < 5; k++) step(1'b0, 0);
    n_cmp++;
    if (obs_code !== 2) begin
      n_bad++;
      $display("FAIL nosop_order: got %0d want 2", obs_code);
    end
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < int'($urandom_range(3, 1)); j++)
          push_burst(i, int'($urandom_range(4, 1)), 1'b1);
      run(30, 25, 0, 3000);
    end
  endtask

  initial begin
    stepno = 0;
    test_reset();
    test_single_lines();
    test_lock();
    test_alm_full();
    test_burst_len();
    test_reset_mid_burst();
    test_no_sop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofs_plat_ccip_c1_burst_arbiter.md
OFS_PLAT_CCIP_C1_BURST_ARBITER -- requirements
Module: ofs_plat_ccip_c1_burst_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, meaning the write-data width per beat.
REQ-003 SHALL have parameter HDR_WIDTH, default 80, meaning the opaque c1 request-header width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port src_valid, input, N_SRC bits: beat offered per source.
REQ-007 SHALL have port src_sop, input, N_SRC bits: beat is the first of a burst.
REQ-008 SHALL have port src_eop, input, N_SRC bits: beat is the last of a burst.
REQ-009 SHALL have port src_hdr, input, N_SRC*HDR_WIDTH bits: per-source header, used on the SOP beat.
REQ-010 SHALL have port src_data, input, N_SRC*DATA_WIDTH bits: per-source beat data.
REQ-011 SHALL have port src_ready, output, N_SRC bits: beat accepted this cycle (valid&&ready).
REQ-012 SHALL have port c1TxAlmFull, input, 1 bit: sink almost-full.
REQ-013 SHALL have port tx_valid, output, 1 bit: registered beat to the sink.
REQ-014 SHALL have port tx_sop, output, 1 bit: registered SOP flag.
REQ-015 SHALL have port tx_hdr, output, HDR_WIDTH bits: registered header.
REQ-016 SHALL have port tx_data, output, DATA_WIDTH bits: registered data.
REQ-017 SHALL have port tx_src, output, $clog2(N_SRC) bits: index of the source of the tx beat.
REQ-018 SHALL have port err_burst_len, output, 1 bit: sticky flag for a burst longer than 4 beats.

Function
REQ-019 SHALL register c1TxAlmFull into alm_full_q; a beat may be accepted only when alm_full_q==0.
REQ-020 SHALL implement states IDLE and LOCKED, with register owner and round-robin pointer rr_ptr.
REQ-021 In IDLE, SHALL grant the first source, searching from rr_ptr upward with wrap, whose valid&&sop are both 1; sources with valid && !sop SHALL NOT be granted.
REQ-022 SHALL assert src_ready only for the granted/owner source, combinationally, when alm_full_q==0; all other src_ready bits SHALL be 0.
REQ-023 When the IDLE grant beat is accepted with eop==0, SHALL move to LOCKED with owner set to the granted source.
REQ-024 When the IDLE grant beat is accepted with eop==1 (single-line burst), SHALL stay in IDLE and set rr_ptr to (grant+1) mod N_SRC.
REQ-025 In LOCKED, SHALL serve only the owner regardless of its sop; on an accepted eop SHALL return to IDLE with rr_ptr set to (owner+1) mod N_SRC.
REQ-026 In LOCKED, the owner deasserting valid SHALL insert a bubble without releasing the lock.
REQ-027 SHALL present each accepted beat on tx_* exactly one cycle after acceptance (tx_valid=1, tx_sop=src_sop, tx_hdr, tx_data, tx_src); with no acceptance, tx_valid SHALL be 0 and the other tx_* fields SHALL hold their values.
REQ-028 SHALL sustain one beat per cycle, including back-to-back bursts from different sources.
REQ-029 SHALL count beats per burst with a 3-bit counter; if a 5th beat is accepted without eop, SHALL set err_burst_len (sticky until reset) and force a return to IDLE after that beat.
REQ-030 An alm_full_q rising mid-burst SHALL stall acceptance but keep the lock; no beat SHALL be dropped or duplicated.

Reset
REQ-031 While reset==1: tx_valid=0, tx_sop=0, tx_hdr=0, tx_data=0, tx_src=0, err_burst_len=0, state=IDLE, rr_ptr=0, beat counter=0, alm_full_q=1; src_ready SHALL be 0 during reset and in the first cycle after it.
REQ-032 Reset asserted mid-burst SHALL abandon the lock; after reset the arbiter SHALL wait for a new SOP.

Verification
REQ-033 Sources 0..3 each offer one 1-line SOP/EOP beat at t0, almFull=0 -> tx_src order 0,1,2,3 on consecutive cycles, tx_valid continuous.
REQ-034 Src1 offers a 4-line burst and src2 offers a 1-line burst together, rr_ptr=0 -> tx_src=1,1,1,1,2; src2 ready stays 0 until src1's EOP is accepted.
REQ-035 c1TxAlmFull=1 after beat 2 of a 3-line burst for 5 cycles -> no src_ready while alm_full_q==1, then beat 3 issued; tx shows beats 1,2,3 exactly once each.
REQ-036 Src0 sends 5 beats with eop=0 -> err_burst_len=1 after the 5th acceptance; next grant goes to another valid SOP source.
REQ-037 Reset pulsed after beat 2 of a 4-line burst -> tx_valid=0; the src0 remainder (sop=0) is not granted; a src3 SOP beat is granted next.
REQ-038 Src2 holds valid=1, sop=0 while idle and src1 offers an SOP -> only src1 is granted; src2 is never granted.
